// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
//
// Purpose:
//   Baud-rate tick generator for a UART. A prescaler divides the system
//   clock by a runtime divisor to produce a one-cycle oversample tick
//   (o_os_tick). An oversample counter divides that by OVERSAMPLE to
//   produce a one-cycle baud tick (o_baud_tick). The baud tick coincides
//   with the last oversample tick of each bit. Baud ticks are counted in
//   o_tick_count. With MAX_TICKS != 0, o_done latches when the limit is
//   reached, and counting then freezes until i_clr.
//
// Ports:
//   i_clk        system clock, rising-edge active
//   i_reset      synchronous, active-low reset
//   i_en         count enable; low freezes all counters
//   i_div_load   strobe: adopt i_div_in (0 is taken as 1) as the divisor
//   i_div_in     runtime divisor, clk cycles per oversample tick
//   i_resync     strobe: restart bit phase at mid-bit (start-bit edge)
//   i_clr        strobe: clear o_tick_count and o_done
//   o_os_tick    one-cycle oversample tick (registered)
//   o_baud_tick  one-cycle baud tick (registered)
//   o_tick_count number of baud ticks issued
//   o_done       tick limit reached (only when MAX_TICKS != 0)
//   o_div_active divisor currently in use
//
// Strobe priority: reset > div_load > resync > clr > counting.
// -----------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int CLK_F      = 25000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16,
   parameter int MAX_TICKS  = 0,
   parameter int CNT_W      = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic             i_div_load,
   input  logic [DIV_W-1:0] i_div_in,
   input  logic             i_resync,
   input  logic             i_clr,
   output logic             o_os_tick,
   output logic             o_baud_tick,
   output logic [CNT_W-1:0] o_tick_count,
   output logic             o_done,
   output logic [DIV_W-1:0] o_div_active
);

   localparam int OS_W        = $clog2(OVERSAMPLE);
   localparam int DEF_DIV_RAW = CLK_F / (BAUD * OVERSAMPLE);
   localparam int DEF_DIV_FLR = (DEF_DIV_RAW < 1) ? 1 : DEF_DIV_RAW;

   localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(DEF_DIV_FLR);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
   localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2);
   localparam logic [OS_W-1:0]  OS_ZERO   = OS_W'(0);
   localparam logic [OS_W-1:0]  OS_ONE    = OS_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_TICKS);
   localparam logic             HAS_LIMIT = (MAX_TICKS != 0);

   // Registered state
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_presc;
   logic [OS_W-1:0]  r_os_cnt;
   logic [CNT_W-1:0] r_tick_cnt;
   logic             r_done;
   logic             r_os_tick;
   logic             r_baud_tick;

   // Next-state values
   logic [DIV_W-1:0] w_div_nxt;
   logic [DIV_W-1:0] w_presc_nxt;
   logic [OS_W-1:0]  w_os_cnt_nxt;
   logic [CNT_W-1:0] w_tick_cnt_nxt;
   logic             w_done_nxt;
   logic             w_os_tick_nxt;
   logic             w_baud_tick_nxt;

   // Helpers
   logic             w_presc_last;
   logic             w_os_last;
   logic [CNT_W-1:0] w_cnt_inc;

   // r_div is never 0, so div-1 cannot underflow.
   assign w_presc_last = (r_presc == (r_div - DIV_ONE));
   assign w_os_last    = (r_os_cnt == OS_LAST);
   assign w_cnt_inc    = r_tick_cnt + CNT_ONE;

   // Next-state and tick decode for prescaler, oversample counter and tick count
   always_comb begin
      w_div_nxt       = r_div;
      w_presc_nxt     = r_presc;
      w_os_cnt_nxt    = r_os_cnt;
      w_tick_cnt_nxt  = r_tick_cnt;
      w_done_nxt      = r_done;
      w_os_tick_nxt   = 1'b0;
      w_baud_tick_nxt = 1'b0;

      if (i_div_load) begin
         // New divisor restarts the bit; any tick due now is dropped.
         w_div_nxt    = (i_div_in == DIV_ZERO) ? DIV_ONE : i_div_in;
         w_presc_nxt  = DIV_ZERO;
         w_os_cnt_nxt = OS_ZERO;
      end else if (i_resync) begin
         // Restart at mid-bit so the next baud tick samples the bit centre.
         w_presc_nxt  = DIV_ZERO;
         w_os_cnt_nxt = OS_HALF;
      end else if (i_clr) begin
         // Clear wins over counting: counters hold for this one cycle.
         w_presc_nxt  = r_presc;
         w_os_cnt_nxt = r_os_cnt;
      end else if (i_en && !r_done) begin
         if (w_presc_last) begin
            w_presc_nxt   = DIV_ZERO;
            w_os_tick_nxt = 1'b1;
            if (w_os_last) begin
               w_os_cnt_nxt    = OS_ZERO;
               w_baud_tick_nxt = 1'b1;
               w_tick_cnt_nxt  = w_cnt_inc;
               if (HAS_LIMIT && (w_cnt_inc == MAX_CNT)) begin
                  w_done_nxt = 1'b1;
               end else begin
                  w_done_nxt = r_done;
               end
            end else begin
               w_os_cnt_nxt = r_os_cnt + OS_ONE;
            end
         end else begin
            w_presc_nxt = r_presc + DIV_ONE;
         end
      end else begin
         // Disabled or limit reached: everything holds.
         w_presc_nxt  = r_presc;
         w_os_cnt_nxt = r_os_cnt;
      end

      // clr still applies its clears underneath a div_load or resync.
      if (i_clr) begin
         w_tick_cnt_nxt = CNT_ZERO;
         w_done_nxt     = 1'b0;
      end else begin
         w_tick_cnt_nxt = w_tick_cnt_nxt;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_div       <= DEF_DIV;
         r_presc     <= DIV_ZERO;
         r_os_cnt    <= OS_ZERO;
         r_tick_cnt  <= CNT_ZERO;
         r_done      <= 1'b0;
         r_os_tick   <= 1'b0;
         r_baud_tick <= 1'b0;
      end else begin
         r_div       <= w_div_nxt;
         r_presc     <= w_presc_nxt;
         r_os_cnt    <= w_os_cnt_nxt;
         r_tick_cnt  <= w_tick_cnt_nxt;
         r_done      <= w_done_nxt;
         r_os_tick   <= w_os_tick_nxt;
         r_baud_tick <= w_baud_tick_nxt;
      end
   end

   assign o_os_tick    = r_os_tick;
   assign o_baud_tick  = r_baud_tick;
   assign o_tick_count = r_tick_cnt;
   assign o_done       = r_done;
   assign o_div_active = r_div;

endmodule
